// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered result stage that sits directly behind alu_32bit_modular. Each
// accepted ALU result (F, Cout) is stored with N/Z/C/V status flags. The flags
// are derived at capture time from the op context (sel, Cin, operand MSBs).
// Results leave in order through a small FIFO. Both sides use a valid/ready
// handshake, so the combinational ALU can feed a consumer that stalls.
//
// Parameters:
//   WIDTH  datapath width (must match the ALU)
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    upstream result valid
//   in_ready    stage can accept (0 while rst_n=0 or when full)
//   in_f        ALU F
//   in_cout     ALU Cout
//   in_sel      ALU sel for this result
//   in_cin      ALU Cin for this result
//   in_a_msb    A[WIDTH-1]
//   in_b_msb    B[WIDTH-1]
//   out_valid   head entry valid
//   out_ready   downstream accepts
//   out_f       head result (0 when out_valid=0)
//   out_flags   head flags {N,Z,C,V} (0 when out_valid=0)
//   count       occupancy
//   clr_sticky  clear sticky overflow
//   sticky_v    sticky overflow
//
// Build option:
//   ALU_RES_STICKY_V_EN  when defined, sticky_v latches any pushed V=1 until
//                        clr_sticky (set wins over clear). When undefined,
//                        sticky_v is tied to 0 and clr_sticky is ignored.
// -----------------------------------------------------------------------------
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_f,
   input  logic                       in_cout,
   input  logic [3:0]                 in_sel,
   input  logic                       in_cin,
   input  logic                       in_a_msb,
   input  logic                       in_b_msb,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_f,
   output logic [3:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       clr_sticky,
   output logic                       sticky_v
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 4;

   // Status flags {N,Z,C,V} for one ALU result. C and V only mean something
   // for arithmetic ops (sel[3:2]==00); logic and shift ops report 0.
   function automatic logic [3:0] calc_flags(
      input logic [WIDTH-1:0] f,
      input logic             cout,
      input logic [3:0]       sel,
      input logic             cin,
      input logic             a,
      input logic             b
   );
      logic n;
      logic z;
      logic c;
      logic v;
      n = f[WIDTH-1];
      z = (f == {WIDTH{1'b0}});
      c = 1'b0;
      v = 1'b0;
      if (sel[3:2] == 2'b00) begin
         c = cout;
         case ({sel[1:0], cin})
            3'b001:         v = ~a & n;               // increment
            3'b010, 3'b011: v = (a == b) & (n != a);  // add
            3'b100, 3'b101: v = (a != b) & (n != a);  // subtract
            3'b110:         v = a & ~n;               // decrement
            default:        v = 1'b0;                 // transfers
         endcase
      end else begin
         c = 1'b0;
         v = 1'b0;
      end
      return {n, z, c, v};
   endfunction

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] wr_data_s;
   logic [EW-1:0] rd_data_s;
   logic          push_s;
   logic          pop_s;

   // Handshake decode; reset forces in_ready low so nothing is captured.
   always_comb begin
      in_ready  = rst_n & (count_q != CW'(DEPTH));
      out_valid = (count_q != {CW{1'b0}});
      push_s    = in_valid & in_ready;
      pop_s     = out_valid & out_ready;
      wr_data_s = {in_f, calc_flags(in_f, in_cout, in_sel, in_cin, in_a_msb, in_b_msb)};
      rd_data_s = mem_q[rd_ptr_q];
   end

   // Next-state for pointers and occupancy; pointers wrap as DEPTH is 2^AW.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; deliberately not reset (push_s is already low in reset).
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_data_s;
      end
   end

   // Head presentation, zeroed while the FIFO is empty.
   always_comb begin
      count = count_q;
      if (out_valid) begin
         out_f     = rd_data_s[EW-1:4];
         out_flags = rd_data_s[3:0];
      end else begin
         out_f     = {WIDTH{1'b0}};
         out_flags = 4'b0000;
      end
   end

`ifdef ALU_RES_STICKY_V_EN
   logic sticky_q, sticky_d;

   // Sticky overflow next-state: a pushed V=1 beats a same-cycle clear.
   always_comb begin
      sticky_d = sticky_q;
      if (push_s && wr_data_s[0]) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_v = sticky_q;
`else
   logic unused_clr_sticky_s;
   assign unused_clr_sticky_s = clr_sticky;
   assign sticky_v            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_f;
   logic              in_cout;
   logic [3:0]        in_sel;
   logic              in_cin;
   logic              in_a_msb;
   logic              in_b_msb;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_f;
   logic [3:0]        out_flags;
   logic [2:0]        count;
   logic              clr_sticky;
   logic              sticky_v;

   int tests_run;
   int tests_failed;

   alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_f(in_f), .in_cout(in_cout), .in_sel(in_sel), .in_cin(in_cin),
      .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_flags(out_flags), .count(count),
      .clr_sticky(clr_sticky), .sticky_v(sticky_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] f, input logic cout, input logic [3:0] sel,
                        input logic cin, input logic a, input logic b);
      in_f = f; in_cout = cout; in_sel = sel; in_cin = cin; in_a_msb = a; in_b_msb = b;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
      drive(32'h0000_00AA, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count); end
      tests_run++; if (out_f !== 32'h0) begin tests_failed++; $display("FAIL reset_out_f got=%h exp=0", out_f); end
      tests_run++; if (sticky_v !== 1'b0) begin tests_failed++; $display("FAIL reset_sticky got=%b exp=0", sticky_v); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL release_empty got valid=%b count=%0d exp 0/0", out_valid, count); end
   endtask

   task automatic test_add_overflow();
      out_ready = 1'b1; in_valid = 1'b1;
      drive(32'h8000_0000, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_f !== 32'h8000_0000) begin tests_failed++; $display("FAIL add_ovf_f got valid=%b f=%h exp 1/80000000", out_valid, out_f); end
      tests_run++; if (out_flags !== 4'b1001) begin tests_failed++; $display("FAIL add_ovf_flags got=%b exp=1001", out_flags); end
      drive(32'hFFFF_FFFF, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      tests_run++; if (out_f !== 32'hFFFF_FFFF || out_flags !== 4'b1000) begin tests_failed++; $display("FAIL add_noovf got f=%h flags=%b exp ffffffff/1000", out_f, out_flags); end
      tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL add_count got=%0d exp=1", count); end
      in_valid = 1'b0;
      tick();
      tests_run++; if (out_valid !== 1'b0 || out_flags !== 4'b0000) begin tests_failed++; $display("FAIL add_drain got valid=%b flags=%b exp 0/0000", out_valid, out_flags); end
   endtask

   task automatic test_subtract();
      out_ready = 1'b1; in_valid = 1'b1;
      drive(32'hFFFF_FFFF, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      tick();
      tests_run++; if (out_flags !== 4'b1000) begin tests_failed++; $display("FAIL sub_neg got=%b exp=1000", out_flags); end
      drive(32'h7FFF_FFFF, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
      tick();
      tests_run++; if (out_flags !== 4'b0011 || out_f !== 32'h7FFF_FFFF) begin tests_failed++; $display("FAIL sub_ovf got f=%h flags=%b exp 7fffffff/0011", out_f, out_flags); end
      drive(32'h0000_0000, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1);
      tick();
      tests_run++; if (out_flags !== 4'b0100) begin tests_failed++; $display("FAIL logic_zero got=%b exp=0100", out_flags); end
      // increment 0x7FFFFFFF -> 0x80000000 overflows
      drive(32'h8000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      tick();
      tests_run++; if (out_flags !== 4'b1001) begin tests_failed++; $display("FAIL inc_ovf got=%b exp=1001", out_flags); end
      // decrement 0x80000000 -> 0x7FFFFFFF overflows, carry reported
      drive(32'h7FFF_FFFF, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
      tick();
      tests_run++; if (out_flags !== 4'b0011) begin tests_failed++; $display("FAIL dec_ovf got=%b exp=0011", out_flags); end
      // transfer (111) never overflows
      drive(32'h8000_0000, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
      tick();
      tests_run++; if (out_flags !== 4'b1000) begin tests_failed++; $display("FAIL xfer got=%b exp=1000", out_flags); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_fill_backpressure();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(32'(i), 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
         tick();
      end
      tests_run++; if (count !== 3'd4 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL full got count=%0d ready=%b exp 4/0", count, in_ready); end
      drive(32'd5, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++; if (count !== 3'd4 || out_f !== 32'd1) begin tests_failed++; $display("FAIL full_reject got count=%0d head=%0d exp 4/1", count, out_f); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tests_run++; if (in_ready !== 1'b1 || count !== 3'd3) begin tests_failed++; $display("FAIL ready_return got ready=%b count=%0d exp 1/3", in_ready, count); end
      tests_run++; if (out_f !== 32'd2) begin tests_failed++; $display("FAIL order_2 got=%0d exp=2", out_f); end
      tick();
      tests_run++; if (out_f !== 32'd3) begin tests_failed++; $display("FAIL order_3 got=%0d exp=3", out_f); end
      tick();
      tests_run++; if (out_f !== 32'd4 || count !== 3'd1) begin tests_failed++; $display("FAIL order_4 got=%0d count=%0d exp 4/1", out_f, count); end
      in_valid = 1'b1;
      drive(32'd5, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++; if (out_f !== 32'd5 || count !== 3'd1) begin tests_failed++; $display("FAIL order_5 got=%0d count=%0d exp 5/1", out_f, count); end
      in_valid = 1'b0;
      tick();
      tests_run++; if (out_valid !== 1'b0 || out_f !== 32'd0) begin tests_failed++; $display("FAIL fill_drain got valid=%b f=%0d exp 0/0", out_valid, out_f); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_valid = 1'b1;
      drive(32'd100, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0); tick();
      drive(32'd101, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0); tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(32'(102 + i), 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
         tests_run++; if (out_f !== 32'(100 + i)) begin tests_failed++; $display("FAIL b2b_head[%0d] got=%0d exp=%0d", i, out_f, 100 + i); end
         tick();
         tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
      end
      in_valid = 1'b0;
      tick(); tick();
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL b2b_drain got=%0d exp=0", count); end
   endtask

   task automatic test_sticky();
      logic exp_set;
`ifdef ALU_RES_STICKY_V_EN
      exp_set = 1'b1;
`else
      exp_set = 1'b0;
`endif
      out_ready = 1'b1; in_valid = 1'b0; clr_sticky = 1'b1;
      tick();
      tests_run++; if (sticky_v !== 1'b0) begin tests_failed++; $display("FAIL sticky_preclear got=%b exp=0", sticky_v); end
      in_valid = 1'b1;
      drive(32'h8000_0000, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++; if (sticky_v !== exp_set) begin tests_failed++; $display("FAIL sticky_set_wins got=%b exp=%b", sticky_v, exp_set); end
      in_valid = 1'b0;
      tick();
      tests_run++; if (sticky_v !== 1'b0) begin tests_failed++; $display("FAIL sticky_clear got=%b exp=0", sticky_v); end
      clr_sticky = 1'b0;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      drive(32'd7, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0); tick(); tick();
      tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL midrst_pre got=%0d exp=2", count); end
      rst_n = 1'b0; out_ready = 1'b1;
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_post got count=%0d valid=%b exp 0/0", count, out_valid); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_add_overflow();
      test_subtract();
      test_fill_backpressure();
      test_back_to_back();
      test_sticky();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
